// File: rtl/dma_control_if.sv
// rtl/dma_control_if.sv - register-slave and DMA-master signal bundle for dma_control
interface dma_control_if #(
  parameter int ADDR_W = 3
);
  logic              iChipselect;
  logic [ADDR_W-1:0] iAddress;
  logic              iWrite;
  logic              iRead;
  logic [31:0]       iWritedata;
  logic [31:0]       oReaddata;
  logic              iWM_done;
  logic              oStart;
  logic [31:0]       oRM_startaddress;
  logic [31:0]       oWM_startaddress;
  logic [31:0]       oLength;
  logic              oIRQ;

  modport slave (
    input  iChipselect, iAddress, iWrite, iRead, iWritedata, iWM_done,
    output oReaddata, oStart, oRM_startaddress, oWM_startaddress, oLength, oIRQ
  );

  modport master (
    output iChipselect, iAddress, iWrite, iRead, iWritedata, iWM_done,
    input  oReaddata, oStart, oRM_startaddress, oWM_startaddress, oLength, oIRQ
  );
endinterface

// File: rtl/dma_control.sv
// rtl/dma_control.sv - DMA register file and transfer sequencer
module dma_control #(
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 32
) (
  input logic          iClk,
  input logic          iReset_n,
  dma_control_if.slave bus
);
  typedef enum logic [1:0] {IDLE, START, RUN, FIN} state_t;

  state_t             state;
  logic [31:0]        srcReg, dstReg, lenReg;
  logic               ieReg, doneReg, errReg;
  logic [CNT_W-1:0]   cycles;
  logic [31:0]        rmAddr, wmAddr, length, readdata, rdMux;
  logic               startReg;

  logic wrEn, rdEn, busy, goWrite, lenBad;

  assign wrEn    = bus.iChipselect & bus.iWrite;
  assign rdEn    = bus.iChipselect & bus.iRead;
  assign busy    = (state == START) || (state == RUN);
  assign goWrite = wrEn && (bus.iAddress == ADDR_W'(3)) && bus.iWritedata[0];
  assign lenBad  = (lenReg == 32'd0) || (lenReg[1:0] != 2'b00);

  always_comb begin
    rdMux = 32'd0;
    case (bus.iAddress)
      ADDR_W'(0): rdMux = srcReg;
      ADDR_W'(1): rdMux = dstReg;
      ADDR_W'(2): rdMux = lenReg;
      ADDR_W'(3): rdMux = {30'd0, ieReg, 1'b0};
      ADDR_W'(4): rdMux = {29'd0, errReg, doneReg, busy};
      ADDR_W'(5): rdMux = 32'(cycles);
      default:    rdMux = 32'd0;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (!iReset_n) begin
      state    <= IDLE;
      srcReg   <= '0;
      dstReg   <= '0;
      lenReg   <= '0;
      ieReg    <= 1'b0;
      doneReg  <= 1'b0;
      errReg   <= 1'b0;
      cycles   <= '0;
      rmAddr   <= '0;
      wmAddr   <= '0;
      length   <= '0;
      readdata <= '0;
      startReg <= 1'b0;
    end else begin
      startReg <= 1'b0;
      if (rdEn)
        readdata <= rdMux;

      if (wrEn) begin
        case (bus.iAddress)
          ADDR_W'(0): if (!busy) srcReg <= bus.iWritedata;
          ADDR_W'(1): if (!busy) dstReg <= bus.iWritedata;
          ADDR_W'(2): if (!busy) lenReg <= bus.iWritedata;
          ADDR_W'(3): ieReg <= bus.iWritedata[1];
          ADDR_W'(4): begin
            if (bus.iWritedata[1]) doneReg <= 1'b0;
            if (bus.iWritedata[2]) errReg  <= 1'b0;
          end
          default: ;
        endcase
      end

      // Sequencer assignments come after the W1C clears so a hardware set wins
      case (state)
        IDLE: begin
          if (goWrite) begin
            if (lenBad) begin
              errReg <= 1'b1;
            end else begin
              rmAddr   <= srcReg;
              wmAddr   <= dstReg;
              length   <= lenReg;
              doneReg  <= 1'b0;
              cycles   <= '0;
              startReg <= 1'b1;
              state    <= START;
            end
          end
        end
        START: state <= RUN;
        RUN: begin
          if (cycles != {CNT_W{1'b1}})
            cycles <= cycles + CNT_W'(1);
          if (bus.iWM_done)
            state <= FIN;
        end
        FIN: begin
          doneReg <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.oReaddata        = readdata;
  assign bus.oStart           = startReg;
  assign bus.oRM_startaddress = rmAddr;
  assign bus.oWM_startaddress = wmAddr;
  assign bus.oLength          = length;
  assign bus.oIRQ             = ieReg & (doneReg | errReg);
endmodule
